// File: rtl/eth_ingress_arbiter.sv
// Frame-atomic round-robin arbiter sharing one AXI4-Stream frame parser between NUM_PORTS ingress ports.
// Define ETH_ARB_FRAME_COUNT_EN to add per-port frame counters on the output side.
module eth_ingress_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 4,
  localparam int PORT_ID_W = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [NUM_PORTS-1:0]            port_enable,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [PORT_ID_W-1:0]            m_axis_tid,
`ifdef ETH_ARB_FRAME_COUNT_EN
  output logic [NUM_PORTS*32-1:0]         frame_count,
`endif
  output logic                            grant_active
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [PORT_ID_W-1:0] grant, last_grant, rr_sel;
  logic                 rr_found, out_ready, accept, frame_end;
  logic [NUM_PORTS-1:0] candidates;
  int                   rr_idx;

  // Enable is only consulted here, so a frame already granted survives a mid-frame disable.
  assign candidates = s_axis_tvalid & port_enable;
  assign out_ready  = !m_axis_tvalid || m_axis_tready;

  // Search upward from the port after the last winner, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      rr_idx = (int'(last_grant) + i) % NUM_PORTS;
      if (!rr_found && candidates[PORT_ID_W'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_sel   = PORT_ID_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (rr_found)  state_nxt = LOCKED;
      LOCKED: if (frame_end) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    accept        = 1'b0;
    frame_end     = 1'b0;
    grant_active  = (state == LOCKED);
    if (state == LOCKED) begin
      s_axis_tready[grant] = out_ready;
      accept               = s_axis_tvalid[grant] && out_ready;
      frame_end            = accept && s_axis_tlast[grant];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= PORT_ID_W'(NUM_PORTS - 1);
    end else begin
      if (state == IDLE && rr_found) grant <= rr_sel;
      if (frame_end)                 last_grant <= grant;
    end
  end

  // Single skid-free output stage: a load may coincide with the drain of the previous beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tlast  <= s_axis_tlast[grant];
      m_axis_tid    <= grant;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef ETH_ARB_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      frame_count[m_axis_tid*32 +: 32] <= frame_count[m_axis_tid*32 +: 32] + 32'd1;
  end
`endif

endmodule

// File: tb/tb_eth_ingress_arbiter.sv
// Randomized bench for eth_ingress_arbiter: per-port source queues and a per-port output scoreboard.
// Frame-counter checks are compiled in when ETH_ARB_FRAME_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_eth_ingress_arbiter;
  localparam int DW = 64;
  localparam int NP = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NP*DW-1:0]      s_tdata;
  logic [NP-1:0]         s_tvalid, s_tready, s_tlast, port_enable;
  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid, m_tready, m_tlast, grant_active;
  logic [$clog2(NP)-1:0] m_tid;
`ifdef ETH_ARB_FRAME_COUNT_EN
  logic [NP*32-1:0]      frame_count;
`endif

  beat_t src_q[NP][$];
  beat_t exp_q[NP][$];
  int    frame_tids[$];
  int    wait_cnt[NP];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    frame_no = 0;
  int    cur_tid = 0;
  int    first_in_cyc = -1;
  int    first_out_cyc = -1;
  bit    rand_ready = 1'b0;
  bit    in_frame = 1'b0;
  bit    port2_ready_seen = 1'b0;

  eth_ingress_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .port_enable   (port_enable),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
`ifdef ETH_ARB_FRAME_COUNT_EN
    .frame_count   (frame_count),
`endif
    .grant_active  (grant_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic pushFrame(input int p, input int nbeats, input int max_gap, input bit expect_out);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {16'(frame_no), 16'(i), 32'hCAFEBABE};
      b.last = (i == nbeats - 1);
      b.gap  = (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      if (src_q[p].size() == 0) wait_cnt[p] = b.gap;
      src_q[p].push_back(b);
      if (expect_out) exp_q[p].push_back(b);
    end
    frame_no++;
  endtask

  function automatic int pendingBeats();
    int n = 0;
    for (int p = 0; p < NP; p++) n += exp_q[p].size();
    return n;
  endfunction

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p]          = 1'b0;
      s_tlast[p]           = 1'b0;
      s_tdata[p*DW +: DW]  = '0;
      if (src_q[p].size() > 0) begin
        if (wait_cnt[p] > 0) begin
          wait_cnt[p]--;
        end else begin
          s_tvalid[p]         = 1'b1;
          s_tdata[p*DW +: DW] = src_q[p][0].data;
          s_tlast[p]          = src_q[p][0].last;
        end
      end
    end
    if (s_tvalid != '0 && first_in_cyc < 0) first_in_cyc = cyc;
    m_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
  endtask

  // One clock: observe handshakes at the falling edge, then advance sources after the rising edge.
  task automatic stepCycle();
    logic [NP-1:0] acc;
    beat_t         eb;
    int            t;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    if (s_tready[2]) port2_ready_seen = 1'b1;
    if (m_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
    if (m_tvalid && m_tready) begin
      t = int'(m_tid);
      if (in_frame) checkOutput("atomic_tid", 64'(t), 64'(cur_tid));
      checkOutput("beat_expected_on_port", 64'(exp_q[t].size() > 0), 64'd1);
      if (exp_q[t].size() > 0) begin
        eb = exp_q[t].pop_front();
        checkOutput("beat_data", m_tdata, eb.data);
        checkOutput("beat_last", 64'(m_tlast), 64'(eb.last));
      end
      in_frame = !m_tlast;
      cur_tid  = t;
      if (m_tlast) frame_tids.push_back(t);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) wait_cnt[p] = src_q[p][0].gap;
      end
    end
    applyStimulus();
  endtask

  task automatic runUntilDone(input int budget);
    int n = 0;
    while (pendingBeats() > 0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_within_budget", 64'(pendingBeats()), 64'd0);
    repeat (3) stepCycle();
  endtask

  task automatic clearModel();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      wait_cnt[p] = 0;
    end
    frame_tids.delete();
    in_frame = 1'b0;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    clearModel();
    applyStimulus();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int port2_beats;
    int enabled_frames;
    rst_n       = 1'b0;
    s_tvalid    = '1;
    s_tlast     = '0;
    s_tdata     = '0;
    port_enable = '1;
    m_tready    = 1'b1;
    for (int p = 0; p < NP; p++) wait_cnt[p] = 0;

    // Reset held with every source requesting.
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
      checkOutput("rst_grant_active", 64'(grant_active), 64'd0);
    end
    checkOutput("rst_m_tdata", m_tdata, 64'd0);
    checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_m_tid", 64'(m_tid), 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_tvalid = '0;

    $display("[TB] single port frame on port 2");
    first_in_cyc  = -1;
    first_out_cyc = -1;
    pushFrame(2, 3, 0, 1'b1);
    runUntilDone(50);
    checkOutput("first_beat_latency", 64'(first_out_cyc - first_in_cyc), 64'd2);
    checkOutput("single_frame_count", 64'(frame_tids.size()), 64'd1);
    checkOutput("idle_grant_active", 64'(grant_active), 64'd0);

    $display("[TB] round robin, all ports busy");
    resetPulse();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) pushFrame(p, 2, 0, 1'b1);
    runUntilDone(200);
    checkOutput("rr_frames", 64'(frame_tids.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("rr_order_%0d", i),
                  64'((i < frame_tids.size()) ? frame_tids[i] : -1), 64'(i % NP));

    $display("[TB] atomicity with source gaps");
    resetPulse();
    pushFrame(0, 3, 3, 1'b1);
    pushFrame(1, 2, 0, 1'b1);
    runUntilDone(100);
    checkOutput("gap_frames", 64'(frame_tids.size()), 64'd2);
    checkOutput("gap_first_port", 64'((frame_tids.size() > 0) ? frame_tids[0] : -1), 64'd0);
    checkOutput("gap_second_port", 64'((frame_tids.size() > 1) ? frame_tids[1] : -1), 64'd1);

    $display("[TB] random backpressure with port 2 disabled");
    resetPulse();
    port_enable      = 4'b1011;
    rand_ready       = 1'b1;
    port2_ready_seen = 1'b0;
    port2_beats      = 0;
    enabled_frames   = 0;
    for (int f = 0; f < 50; f++) begin
      int p;
      int len;
      p   = int'($urandom_range(NP - 1, 0));
      len = int'($urandom_range(4, 1));
      pushFrame(p, len, 2, p != 2);
      if (p == 2) port2_beats += len;
      else        enabled_frames++;
    end
    runUntilDone(3000);
    checkOutput("bp_frames", 64'(frame_tids.size()), 64'(enabled_frames));
    checkOutput("bp_port2_ready", 64'(port2_ready_seen), 64'd0);
    checkOutput("bp_port2_untouched", 64'(src_q[2].size()), 64'(port2_beats));
    rand_ready = 1'b0;
    resetPulse();
    port_enable = '1;

    $display("[TB] reset in the middle of a frame");
    pushFrame(3, 3, 0, 1'b1);
    n = 0;
    while (exp_q[3].size() == 3 && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("mid_first_beat_seen", 64'(exp_q[3].size()), 64'd2);
    rst_n = 1'b0;
    clearModel();
    applyStimulus();
    @(negedge clk);
    checkOutput("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("mid_rst_m_tdata", m_tdata, 64'd0);
    checkOutput("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("mid_rst_m_tid", 64'(m_tid), 64'd0);
    checkOutput("mid_rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("mid_rst_grant_active", 64'(grant_active), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef ETH_ARB_FRAME_COUNT_EN
    checkOutput("cnt_after_reset", 64'(frame_count != '0), 64'd0);
`endif
    pushFrame(0, 2, 0, 1'b1);
    runUntilDone(50);
    checkOutput("post_rst_frames", 64'(frame_tids.size()), 64'd1);
    checkOutput("post_rst_port", 64'((frame_tids.size() > 0) ? frame_tids[0] : -1), 64'd0);
`ifdef ETH_ARB_FRAME_COUNT_EN
    checkOutput("cnt_port0", 64'(frame_count[31:0]), 64'd1);
    checkOutput("cnt_others", 64'(frame_count[NP*32-1:32] != '0), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_ingress_arbiter.md
Name: eth_ingress_arbiter

Overview:
Frame-atomic round-robin arbiter that shares one ethernet_frame_parser between NUM_PORTS AXI4-Stream ingress ports. It sits directly upstream of the parser s_axis interface. It grants one port per frame and holds the grant until that port's tlast beat is accepted. It forwards beats through a single output register and tags each beat with its source port ID.

Parameters:
DATA_WIDTH, 64, tdata width per port and on the output; must equal the parser DATA_WIDTH.
NUM_PORTS, 4, number of ingress ports; legal range 2..16.
PORT_ID_W, $clog2(NUM_PORTS), width of the port ID tag; derived, not overridden.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  input  NUM_PORTS  per-port valid
s_axis_tready  output  NUM_PORTS  per-port ready
s_axis_tlast  input  NUM_PORTS  per-port end of frame
port_enable  input  NUM_PORTS  config mask; 0 excludes the port from new grants
m_axis_tdata  output  DATA_WIDTH  to parser s_axis_tdata
m_axis_tvalid  output  1  to parser
m_axis_tready  input  1  from parser
m_axis_tlast  output  1  to parser
m_axis_tid  output  PORT_ID_W  source port of the current output beat
grant_active  output  1  high while a frame grant is held (LOCKED)

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0.
  - s_axis_tready=0, grant_active=0.
- Two states: IDLE and LOCKED.
- IDLE:
  - Candidates are ports with s_axis_tvalid[p] & port_enable[p].
  - If any candidate exists, select the first one searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Register the selection into grant and go to LOCKED next cycle.
  - No beat is accepted in IDLE. One bubble cycle per frame is required.
- LOCKED:
  - s_axis_tready[p] = (p==grant) & (!m_axis_tvalid | m_axis_tready); this is combinational.
  - All other ports see tready=0.
  - Port enable is sampled only at grant time. Deasserting port_enable mid-frame does not abort the frame.
  - Source-side tvalid gaps inside a frame hold the grant. No other port is serviced until the tlast beat is accepted.
  - When the granted port's tlast beat is accepted: last_grant<=grant and state<=IDLE.
- Output register:
  - On an accepted input beat, load tdata, tlast and tid=grant, and set m_axis_tvalid=1.
  - Else, if m_axis_tready, clear m_axis_tvalid.
  - Output fields are held stable while m_axis_tvalid & !m_axis_tready.
  - Simultaneous drain and load in the same cycle is allowed; full throughput is 1 beat/cycle within a frame.
- Latency: an input beat accepted in cycle N appears on m_axis in cycle N+1.
- Ordering: beats are never dropped, duplicated, reordered or interleaved across frames.
- A single-beat frame (tlast on the first beat) is legal: LOCKED for one accept, then IDLE.
- If no candidate exists in IDLE, remain in IDLE and leave last_grant unchanged.
- Reset mid-frame discards any held output beat and any partial grant; behaviour is then as after power-up reset.

Optional Feature:
ETH_ARB_FRAME_COUNT_EN:
- Defined: adds output frame_count [NUM_PORTS*32], with port p in bits [p*32 +: 32].
  - Counter m_axis_tid increments by 1 on each m_axis_tvalid & m_axis_tready & m_axis_tlast.
  - Counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Undefined: the port and its counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with all s_axis_tvalid=1 -> m_axis_tvalid=0, s_axis_tready=0, grant_active=0 throughout.
- Single port: port 2 sends 3 beats {16'(f),16'(beat),32'hCAFEBABE} with m_axis_tready=1 -> 3 output beats in order, m_axis_tid=2, tlast only on beat 2, first beat on m_axis 2 cycles after tvalid.
- Round robin: all 4 ports continuously offer 2-beat frames, 8 frames total -> m_axis_tid frame order 0,1,2,3,0,1,2,3.
- Atomicity under gaps: port 0 sends 3 beats with 0-3 idle cycles between them while port 1 holds tvalid -> all port 0 beats precede any port 1 beat; no interleave.
- Backpressure plus config: random m_axis_tready (50%) on 50 frames over 4 ports, with port_enable=4'b1011 -> scoreboard exact match per port, no port 2 beats, port 2 tready stays 0.
- Reset mid-frame: assert rst_n=0 after beat 1 of a 3-beat frame on port 3 -> outputs return to reset values. The next frame from port 0 passes cleanly. With ETH_ARB_FRAME_COUNT_EN, all counters read 0 after reset, then port 0 counter reads 1.
